// File: rtl/pdm_dec_if.sv
// Host register bus for the stereo PDM decimator: chip select, byte write
// enables, address, write data and registered read data.
interface pdm_dec_if;
    logic        cs;
    logic [3:0]  we;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output cs, we, addr, din, input dout);
    modport slave  (input cs, we, addr, din, output dout);
endinterface

// File: rtl/pdm_dec.sv
// Stereo PDM microphone decimator: clock generator, per-channel 3rd-order CIC,
// 16-entry output FIFO and a two-register host interface.
module pdm_dec #(
    parameter int CLKDIV = 8,
    parameter int DEC    = 64
) (
    input  logic     clk,
    input  logic     reset,
    pdm_dec_if.slave bus,
    output logic     pdm_clk,
    input  logic     pdm_dat
);
    localparam int LOG2DEC = $clog2(DEC);
    localparam int W       = 3 * LOG2DEC + 2;
    localparam int SHIFT   = 3 * LOG2DEC - 15;
    localparam int SHR     = (SHIFT > 0) ? SHIFT : 0;
    localparam int SHL     = (SHIFT < 0) ? -SHIFT : 0;
    localparam int EW      = W + 3;
    localparam int DIVW    = $clog2(CLKDIV);

    logic [1:0]          r_datSync;
    logic                r_enable;
    logic                r_overrun;
    logic [DIVW-1:0]     r_div;
    logic [LOG2DEC-1:0]  r_decCnt;
    logic                r_rightBit;
    logic signed [W-1:0] r_int1 [2];
    logic signed [W-1:0] r_int2 [2];
    logic signed [W-1:0] r_int3 [2];
    logic signed [W-1:0] r_comb1 [2];
    logic signed [W-1:0] r_comb2 [2];
    logic signed [W-1:0] r_comb3 [2];
    logic [31:0]         r_mem [16];
    logic [3:0]          r_wrPtr;
    logic [3:0]          r_rdPtr;
    logic [4:0]          r_count;

    logic                w_busRead, w_busWrite, w_ctrlWrite, w_flush;
    logic                w_tick, w_frameEnd, w_full, w_pop, w_pushOk, w_overflow;
    logic                w_bit;
    logic signed [W-1:0] w_step;
    logic signed [W-1:0] w_int1Next [2];
    logic signed [W-1:0] w_int2Next [2];
    logic signed [W-1:0] w_int3Next [2];
    logic signed [W-1:0] w_comb1 [2];
    logic signed [W-1:0] w_comb2 [2];
    logic signed [W-1:0] w_comb3 [2];
    logic [15:0]         w_pcm [2];
    logic [31:0]         w_word;
    logic [31:0]         w_status;
    logic                w_unused;

    function automatic logic [15:0] scaleSat(input logic signed [W-1:0] value);
        logic signed [EW-1:0] scaled;
        scaled = EW'(value);
        scaled = (scaled >>> SHR) <<< SHL;
        if (scaled > EW'(32767))
            return 16'h7FFF;
        else if (scaled < EW'(-32768))
            return 16'h8000;
        else
            return scaled[15:0];
    endfunction

    assign w_busRead   = bus.cs && (bus.we == 4'b0000);
    assign w_busWrite  = bus.cs && (bus.we != 4'b0000);
    assign w_ctrlWrite = w_busWrite && bus.addr[0];
    assign w_flush     = w_ctrlWrite && bus.din[2];
    assign w_tick      = r_enable && (r_div == DIVW'(CLKDIV - 1));
    assign w_frameEnd  = w_tick && (&r_decCnt);
    assign w_full      = (r_count == 5'd16);
    assign w_pop       = w_busRead && !bus.addr[0] && (r_count != 5'd0);
    assign w_pushOk    = w_frameEnd && (!w_full || w_pop);
    assign w_overflow  = w_frameEnd && w_full && !w_pop;
    assign w_word      = {w_pcm[1], w_pcm[0]};
    assign w_status    = {22'b0, r_enable, r_overrun, 3'b0, r_count};
    assign pdm_clk     = r_enable && (r_div < DIVW'(CLKDIV / 2));
    assign w_unused    = ^{bus.addr[7:1], bus.din[31:3]};

    always_ff @(posedge clk) begin
        if (reset)
            r_datSync <= 2'b00;
        else
            r_datSync <= {r_datSync[0], pdm_dat};
    end

    // Channel 0 is left (sampled at the tick itself), channel 1 is right (held from mid-period).
    always_comb begin
        w_bit  = 1'b0;
        w_step = '0;
        for (int ch = 0; ch < 2; ch++) begin
            w_bit          = (ch == 0) ? r_datSync[1] : r_rightBit;
            w_step         = w_bit ? W'(1) : '1;
            w_int1Next[ch] = r_int1[ch] + w_step;
            w_int2Next[ch] = r_int2[ch] + w_int1Next[ch];
            w_int3Next[ch] = r_int3[ch] + w_int2Next[ch];
            w_comb1[ch]    = w_int3Next[ch] - r_comb1[ch];
            w_comb2[ch]    = w_comb1[ch] - r_comb2[ch];
            w_comb3[ch]    = w_comb2[ch] - r_comb3[ch];
            w_pcm[ch]      = scaleSat(w_comb3[ch]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !r_enable) begin
            r_div      <= '0;
            r_decCnt   <= '0;
            r_rightBit <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                r_int1[ch]  <= '0;
                r_int2[ch]  <= '0;
                r_int3[ch]  <= '0;
                r_comb1[ch] <= '0;
                r_comb2[ch] <= '0;
                r_comb3[ch] <= '0;
            end
        end else begin
            r_div <= (r_div == DIVW'(CLKDIV - 1)) ? '0 : r_div + DIVW'(1);
            if (r_div == DIVW'(CLKDIV / 2 - 1))
                r_rightBit <= r_datSync[1];
            if (w_tick) begin
                r_decCnt <= r_decCnt + LOG2DEC'(1);
                for (int ch = 0; ch < 2; ch++) begin
                    r_int1[ch] <= w_int1Next[ch];
                    r_int2[ch] <= w_int2Next[ch];
                    r_int3[ch] <= w_int3Next[ch];
                    if (w_frameEnd) begin
                        r_comb1[ch] <= w_int3Next[ch];
                        r_comb2[ch] <= w_comb1[ch];
                        r_comb3[ch] <= w_comb2[ch];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !w_flush && w_pushOk)
            r_mem[r_wrPtr] <= w_word;
    end

    // Overrun set wins over a same-cycle clear so a lost word is never hidden.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable  <= 1'b0;
            r_overrun <= 1'b0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            bus.dout  <= '0;
        end else begin
            if (w_ctrlWrite)
                r_enable <= bus.din[0];
            if (w_overflow)
                r_overrun <= 1'b1;
            else if (w_ctrlWrite && bus.din[1])
                r_overrun <= 1'b0;
            if (w_flush) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
                r_count <= '0;
            end else begin
                if (w_pushOk)
                    r_wrPtr <= r_wrPtr + 4'd1;
                if (w_pop)
                    r_rdPtr <= r_rdPtr + 4'd1;
                if (w_pushOk && !w_pop)
                    r_count <= r_count + 5'd1;
                else if (!w_pushOk && w_pop)
                    r_count <= r_count - 5'd1;
            end
            if (w_busRead) begin
                if (bus.addr[0])
                    bus.dout <= w_status;
                else if (r_count != 5'd0)
                    bus.dout <= r_mem[r_rdPtr];
                else
                    bus.dout <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pdm_dec.sv
// Directed self-checking bench for pdm_dec with CLKDIV=8, DEC=64 (512 clk per word).
module tb_pdm_dec;
    logic clk = 1'b0;
    logic reset;
    logic pdm_clk;
    logic pdm_dat;
    logic togBit = 1'b0;
    int   datMode = 0;
    int   passCount = 0;
    int   failCount = 0;
    int   checkCount = 0;
    int   cycleCount = 0;

    pdm_dec_if busIf ();

    pdm_dec #(.CLKDIV(8), .DEC(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (busIf),
        .pdm_clk (pdm_clk),
        .pdm_dat (pdm_dat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Data changes right after the rising PDM clock so both channel samples see the same bit.
    always @(posedge pdm_clk) togBit <= ~togBit;

    assign pdm_dat = (datMode == 2) ? togBit : (datMode == 1);

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] we, input logic [7:0] addr,
                                 input logic [31:0] din, output logic [31:0] rdata);
        busIf.cs   = 1'b1;
        busIf.we   = we;
        busIf.addr = addr;
        busIf.din  = din;
        @(negedge clk);
        busIf.cs   = 1'b0;
        busIf.we   = 4'h0;
        rdata      = busIf.dout;
    endtask

    task automatic readReg(input logic [7:0] addr, output logic [31:0] data);
        applyStimulus(4'h0, addr, 32'h0, data);
    endtask

    task automatic writeReg(input logic [7:0] addr, input logic [31:0] data);
        logic [31:0] unusedData;
        applyStimulus(4'hF, addr, data, unusedData);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic getWord(output logic [31:0] word, output int arrival);
        logic [31:0] st;
        bit          arrived;
        arrived = 1'b0;
        arrival = 0;
        for (int i = 0; i < 2000 && !arrived; i++) begin
            readReg(8'h01, st);
            if (st[4:0] != 5'd0) begin
                arrived = 1'b1;
                arrival = cycleCount;
            end
        end
        checkOutput("wordArrival", {31'b0, arrived}, 32'h1);
        readReg(8'h00, word);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] word;
        int          tPrev;
        int          tNow;
        tPrev      = 0;
        busIf.cs   = 1'b0;
        busIf.we   = 4'h0;
        busIf.addr = 8'h00;
        busIf.din  = 32'h0;
        reset      = 1'b1;
        waitCycles(3);
        checkOutput("resetDout", busIf.dout, 32'h0);
        checkOutput("resetPdmClk", {31'b0, pdm_clk}, 32'h0);
        reset = 1'b0;
        readReg(8'h01, rd);
        checkOutput("resetStatus", rd, 32'h0);

        writeReg(8'h00, 32'h1);
        readReg(8'h01, rd);
        checkOutput("addr0WriteIgnored", rd, 32'h0);

        $display("[TB] constant one input");
        datMode = 1;
        writeReg(8'h01, 32'h1);
        checkOutput("pdmClkCount0", {31'b0, pdm_clk}, 32'h1);
        waitCycles(3);
        checkOutput("pdmClkCount3", {31'b0, pdm_clk}, 32'h1);
        waitCycles(1);
        checkOutput("pdmClkCount4", {31'b0, pdm_clk}, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            getWord(word, tNow);
            if (k >= 2)
                checkOutput($sformatf("wordSpacing%0d", k), tNow - tPrev, 32'd512);
            if (k >= 4)
                checkOutput($sformatf("posWord%0d", k), word, 32'h7FFF7FFF);
            tPrev = tNow;
        end

        $display("[TB] constant zero input");
        datMode = 0;
        for (int k = 1; k <= 6; k++) begin
            getWord(word, tNow);
            if (k >= 5)
                checkOutput($sformatf("negWord%0d", k), word, 32'h80008000);
        end

        $display("[TB] alternating input");
        datMode = 2;
        for (int k = 1; k <= 6; k++) begin
            getWord(word, tNow);
            if (k >= 5)
                checkOutput($sformatf("zeroWord%0d", k), word, 32'h00000000);
        end

        $display("[TB] overrun");
        datMode = 1;
        waitCycles(17 * 512 + 16);
        readReg(8'h01, rd);
        checkOutput("overrunStatus", rd, 32'h00000310);
        writeReg(8'h01, 32'h3);
        readReg(8'h01, rd);
        checkOutput("overrunCleared", rd, 32'h00000210);

        for (int k = 0; k < 16; k++)
            readReg(8'h00, word);
        checkOutput("lastDrainedWord", word, 32'h7FFF7FFF);
        readReg(8'h00, rd);
        checkOutput("emptyReadDout", rd, 32'h0);
        readReg(8'h01, rd);
        checkOutput("emptyStatus", rd, 32'h00000200);

        $display("[TB] flush");
        waitCycles(3 * 512);
        readReg(8'h01, rd);
        checkOutput("queuedThree", rd, 32'h00000203);
        writeReg(8'h01, 32'h5);
        readReg(8'h01, rd);
        checkOutput("flushStatus", rd, 32'h00000200);

        $display("[TB] reset mid-frame");
        waitCycles(5 * 512);
        readReg(8'h01, rd);
        checkOutput("queuedFive", rd, 32'h00000205);
        waitCycles(100);
        reset      = 1'b1;
        busIf.cs   = 1'b1;
        busIf.we   = 4'hF;
        busIf.addr = 8'h01;
        busIf.din  = 32'h1;
        @(negedge clk);
        checkOutput("midResetDout", busIf.dout, 32'h0);
        checkOutput("midResetPdmClk", {31'b0, pdm_clk}, 32'h0);
        reset    = 1'b0;
        busIf.cs = 1'b0;
        busIf.we = 4'h0;
        readReg(8'h01, rd);
        checkOutput("postResetStatus", rd, 32'h0);
        waitCycles(600);
        readReg(8'h01, rd);
        checkOutput("noPushAfterReset", rd, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/pdm_dec.md
PDM_DEC -- requirements
Module: pdm_dec

Interface
REQ-001 SHALL have parameter CLKDIV, default 8: system clocks per PDM clock period; even, >=4.
REQ-002 SHALL have parameter DEC, default 64: decimation ratio; power of 2, 16..256.
REQ-003 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cs, input, 1: bus chip select.
REQ-006 SHALL have port we, input, 4: byte write enables; any bit set = write, all clear = read.
REQ-007 SHALL have port addr, input, 8: register select; only addr[0] decoded.
REQ-008 SHALL have port din, input, 32: bus write data.
REQ-009 SHALL have port dout, output, 32: registered bus read data.
REQ-010 SHALL have port pdm_clk, output, 1: clock to stereo PDM microphones.
REQ-011 SHALL have port pdm_dat, input, 1: shared stereo PDM data from microphones; asynchronous.

Function
REQ-012 SHALL pass pdm_dat through a 2-flop synchronizer before use.
REQ-013 SHALL run divider counter 0..CLKDIV-1 while enabled; pdm_clk = 1 for counts 0..CLKDIV/2-1, else 0.
REQ-014 SHALL sample the right channel at count CLKDIV/2-1 and the left channel at count CLKDIV-1.
REQ-015 SHALL map sampled bit 1 to +1 and 0 to -1.
REQ-016 SHALL filter each channel with an independent 3rd-order CIC decimator (3 integrators at PDM rate, decimate by DEC, 3 combs).
REQ-017 SHALL use CIC width W = 3*log2(DEC)+2 bits in two's complement; integrators SHALL wrap modulo 2^W.
REQ-018 SHALL derive each 16-bit output as CIC result arithmetic-shifted right by 3*log2(DEC)-15, saturated to -32768..+32767.
REQ-019 SHALL produce one stereo word {right[15:0], left[15:0]} every DEC PDM periods (DEC*CLKDIV clk cycles), after the left sample completing the frame.
REQ-020 SHALL push each word into a 16-entry FIFO.
REQ-021 SHALL discard the new word when the FIFO is full with no simultaneous pop, and set the sticky overrun flag.
REQ-022 SHALL accept a push on the same cycle as a pop when full; count is unchanged.
REQ-023 SHALL load the FIFO head into dout on a read of addr[0]=0 (cs=1, we=0), and pop it on that cycle.
REQ-024 SHALL, on a read of addr[0]=0 while empty, load dout=0 and leave the FIFO unchanged.
REQ-025 SHALL, on a read of addr[0]=1, load dout = {22'b0, enable[9], overrun[8], 3'b0, count[4:0]}.
REQ-026 SHALL make dout valid on the clk edge following the read cycle; it holds until the next read.
REQ-027 SHALL, on a write to addr[0]=1, decode din[0] as the enable value (stored).
REQ-028 SHALL, on the same write, clear overrun when din[1]=1 (write-1-to-clear).
REQ-029 SHALL, on the same write, empty the FIFO when din[2]=1 (flush).
REQ-030 SHALL ignore writes to addr[0]=0.
REQ-031 SHALL, while enable=0, hold pdm_clk=0 and the divider at 0, clear all CIC state and the decimation counter, and push nothing; FIFO contents and reads remain unaffected.
REQ-032 SHALL make FIFO count range 0..16; count 16 = full.

Reset
REQ-033 SHALL, on reset, drive enable=0, overrun=0, FIFO empty, count=0, dout=0, pdm_clk=0, divider/CIC/decimation state=0.
REQ-034 SHALL, on reset mid-frame, abort the partial frame with no push, taking priority over any same-cycle bus access.

Verification
REQ-035 SHALL cover: CLKDIV=8, DEC=64, pdm_dat=1 constant, enable -> after 3 discarded words, every word = 0x7FFF7FFF; words spaced 512 clk.
REQ-036 SHALL cover: pdm_dat=0 constant -> settled words = 0x80008000.
REQ-037 SHALL cover: pdm_dat toggling once per PDM period (L,R equal) -> settled words = 0x00000000.
REQ-038 SHALL cover: no reads for 17 words -> status count=16, overrun=1; write 0x3 to addr 1 -> overrun=0, enable stays 1.
REQ-039 SHALL cover: read addr 0 when empty -> dout=0, count remains 0; then write 0x5 (flush) with data queued -> count=0.
REQ-040 SHALL cover: reset asserted mid-frame with 5 words queued -> count=0, pdm_clk=0, enable=0, dout=0 on the next cycle.
